// File: rtl/key_mem_pkg.sv
// Shared definitions for key_mem and its reader: default geometry and reader FSM encoding.
package key_mem_pkg;

  localparam int KEY_ADDR_WIDTH = 10;
  localparam int KEY_DATA_WIDTH = 32;
  localparam int KEY_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/key_rd_fifo.sv
// Small synchronous FIFO holding key words plus their last tag for the reader's output stream.
module key_rd_fifo
  import key_mem_pkg::*;
#(
  parameter int DEPTH = KEY_FIFO_DEPTH,
  parameter int WIDTH = KEY_DATA_WIDTH + 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; data only, no reset needed since empty masks it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_mem_reader.sv
// Burst reader for key_mem: issues credit-limited reads and streams the words out over AXI-Stream.
module key_mem_reader
  import key_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = KEY_ADDR_WIDTH,
  parameter int DATA_WIDTH = KEY_DATA_WIDTH,
  parameter int FIFO_DEPTH = KEY_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;

  rd_state_t             state;
  rd_state_t             state_n;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [LEN_W-1:0]      issue_cnt;
  logic [LEN_W-1:0]      out_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  zero_done;
  logic                  rd_en;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  beat_last;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      credit_used;
  logic [DATA_WIDTH:0]   fifo_wdata;
  logic [DATA_WIDTH:0]   fifo_rdata;

  // Credits count both buffered words and the read whose data is still on its way back.
  assign credit_used = fifo_count + CNT_W'(inflight);
  assign flush       = abort && (state != IDLE);
  assign push        = inflight && !flush;
  assign fifo_wdata  = {inflight_last, mem_read_data};
  assign pop         = m_axis_tvalid && m_axis_tready && !flush;
  assign beat_last   = pop && fifo_rdata[DATA_WIDTH];

  assign busy            = (state != IDLE);
  assign mem_read_enable = rd_en;
  assign mem_read_addr   = issue_addr;
  assign m_axis_tvalid   = !fifo_empty;
  assign m_axis_tdata    = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
  assign m_axis_tlast    = !fifo_empty && fifo_rdata[DATA_WIDTH];

  key_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, read issue and done pulse.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    done    = zero_done;
    case (state)
      IDLE: begin
        if (start && (length != '0)) state_n = RUN;
      end
      RUN: begin
        rd_en = (issue_cnt != '0) && (credit_used < CNT_W'(FIFO_DEPTH));
        if (abort)          state_n = IDLE;
        else if (beat_last) state_n = DONE;
      end
      DONE: begin
        done    = !abort;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Burst counters, read address and the one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_addr    <= '0;
      issue_cnt     <= '0;
      out_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      zero_done     <= (state == IDLE) && start && (length == '0);
      inflight      <= rd_en && !flush;
      inflight_last <= rd_en && (issue_cnt == LEN_W'(1));
      if ((state == IDLE) && start && (length != '0)) begin
        issue_addr <= base_addr;
        issue_cnt  <= length;
        out_cnt    <= length;
      end else begin
        if (rd_en) begin
          issue_addr <= issue_addr + 1'b1;
          issue_cnt  <= issue_cnt - 1'b1;
        end
        if (pop) out_cnt <= out_cnt - 1'b1;
      end
    end
  end

  // The credit rule must never let a word land in a full buffer.
  assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

  // The tagged last word must coincide with the final outstanding beat.
  assert property (@(posedge clk) disable iff (!reset) beat_last |-> (out_cnt == LEN_W'(1)));

endmodule
